// File: rtl/gf64_pow_seq.sv
// Constant-time square-and-multiply exponentiator over GF(2^6) behind a valid/ready stream.
// Computes x^EXP_FWD or x^EXP_INV in 6 update cycles; the result is held in DONE until out_ready.
module gf64_pow_seq #(
   parameter logic [6:0] POLY    = 7'h43,
   parameter logic [5:0] EXP_INV = 6'd40,
   parameter logic [5:0] EXP_FWD = 6'd52
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [5:0] in_data,
   input  logic       in_fwd,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [5:0] out_data,
   output logic       busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0] state;
   logic [5:0] acc;
   logic [5:0] base;
   logic [5:0] exp_r;
   logic [2:0] cnt;

   logic [5:0] sq;
   logic [5:0] prod;
   logic [5:0] acc_nxt;

   function automatic logic [5:0] gf_reduce(input logic [10:0] p);
      logic [10:0] r;
      r = p;
      for (int i = 10; i >= 6; i--) begin
         if (r[i]) r = r ^ ({4'b0, POLY} << (i - 6));
      end
      return r[5:0];
   endfunction

   function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
      logic [10:0] p;
      p = '0;
      for (int i = 0; i < 6; i++) begin
         if (b[i]) p = p ^ ({5'b0, a} << i);
      end
      return gf_reduce(p);
   endfunction

   // Squaring in characteristic 2 is linear: spread the bits, then reduce.
   function automatic logic [5:0] gf_sq(input logic [5:0] a);
      logic [10:0] p;
      p = '0;
      for (int i = 0; i < 6; i++) begin
         p[2*i] = a[i];
      end
      return gf_reduce(p);
   endfunction

   // The product is always evaluated; the exponent bit only steers the mux.
   always_comb begin
      sq      = gf_sq(acc);
      prod    = gf_mul(sq, base);
      acc_nxt = exp_r[cnt] ? prod : sq;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         base  <= '0;
         exp_r <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  base  <= in_data;
                  exp_r <= in_fwd ? EXP_FWD : EXP_INV;
                  acc   <= 6'h01;
                  cnt   <= 3'd5;
                  state <= BUSY;
               end
            end
            BUSY: begin
               acc <= acc_nxt;
               if (cnt == 3'd0) state <= DONE;
               else             cnt   <= cnt - 3'd1;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_data  = (state == DONE) ? acc : 6'h00;

endmodule
